// File: rtl/rv32i_instr_encoder_if.sv
// rv32i_instr_encoder_if
// Purpose: request and output bus of the RV32I instruction encoder.
//   master : request producer / word consumer (loader, test generator, bench)
//   slave  : the encoder itself
// Signals:
//   in_valid/in_ready     request handshake
//   in_format             0=R 1=I 2=S 3=B 4=U 5=J, 6/7 illegal
//   in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm   request fields
//   out_valid/out_ready   word handshake
//   out_instr, out_addr   encoded word at FIFO head and its word address
interface rv32i_instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_format;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;

  modport master (
    output in_valid, in_format, in_opcode, in_funct3, in_funct7,
           in_rd, in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr
  );

  modport slave (
    input  in_valid, in_format, in_opcode, in_funct3, in_funct7,
           in_rd, in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr
  );
endinterface

// File: rtl/rv32i_instr_encoder.sv
// rv32i_instr_encoder
// Purpose: packs field-level requests into 32-bit RV32I instruction words and
//   drains them through a 2-entry FIFO, each word tagged with its address.
// Parameters:
//   BASE_ADDR  address of the first word after reset/flush
//   ADDR_STEP  address increment per emitted word (bytes)
// Ports:
//   clk    clock, all state updates on posedge
//   reset  synchronous active-high reset (priority over flush)
//   flush  synchronous clear of FIFO, address and err
//   bus    rv32i_instr_encoder_if.slave request/output bus
//   err    sticky error: illegal format or (optional) immediate out of range
// Configuration:
//   ENCODER_IMM_CHECK_EN  when defined, requests whose immediate does not fit
//                         the format are dropped and raise err; otherwise the
//                         immediate is silently truncated to its fields.
module rv32i_instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          ADDR_STEP = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  rv32i_instr_encoder_if.slave     bus,
  output logic                     err
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_t;

  occ_t        state, state_next;
  logic [31:0] mem [2];
  logic        wr_ptr, rd_ptr;
  logic [31:0] addr_q;
  logic [31:0] instr;
  logic [11:0] i_imm;
  logic        shift_form;
  logic        fmt_bad, imm_bad;
  logic        accept, push, pop;

  assign bus.in_ready  = (state != FULL);
  assign bus.out_valid = (state != EMPTY);
  assign bus.out_instr = bus.out_valid ? mem[rd_ptr] : 32'h0;
  assign bus.out_addr  = addr_q;

  assign accept = bus.in_valid & bus.in_ready;
  assign pop    = bus.out_valid & bus.out_ready;
  // Dropped requests (bad format/immediate) and flush-cycle requests never reach the FIFO.
  assign push   = accept & ~fmt_bad & ~imm_bad & ~flush;

  // Field packing. SLLI/SRLI/SRAI carry funct7 in the upper immediate bits.
  always_comb begin
    shift_form = (bus.in_opcode == 7'b0010011) &&
                 ((bus.in_funct3 == 3'b001) || (bus.in_funct3 == 3'b101));
    i_imm      = shift_form ? {bus.in_funct7, bus.in_imm[4:0]} : bus.in_imm[11:0];
    fmt_bad    = 1'b0;
    instr      = 32'h0;
    case (bus.in_format)
      3'd0: instr = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3,
                     bus.in_rd, bus.in_opcode};
      3'd1: instr = {i_imm, bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
      3'd2: instr = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                     bus.in_imm[4:0], bus.in_opcode};
      3'd3: instr = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1,
                     bus.in_funct3, bus.in_imm[4:1], bus.in_imm[11], bus.in_opcode};
      3'd4: instr = {bus.in_imm[31:12], bus.in_rd, bus.in_opcode};
      3'd5: instr = {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11],
                     bus.in_imm[19:12], bus.in_rd, bus.in_opcode};
      default: fmt_bad = 1'b1;
    endcase
  end

  // Range checks: a signed value fits when every bit above the field's sign
  // bit equals that sign bit; B/J offsets must also be even.
  always_comb begin
    imm_bad = 1'b0;
`ifdef ENCODER_IMM_CHECK_EN
    case (bus.in_format)
      3'd1: imm_bad = ~shift_form &
                      ~((~|bus.in_imm[31:11]) | (&bus.in_imm[31:11]));
      3'd2: imm_bad = ~((~|bus.in_imm[31:11]) | (&bus.in_imm[31:11]));
      3'd3: imm_bad = ~((~|bus.in_imm[31:12]) | (&bus.in_imm[31:12])) | bus.in_imm[0];
      3'd4: imm_bad = |bus.in_imm[11:0];
      3'd5: imm_bad = ~((~|bus.in_imm[31:20]) | (&bus.in_imm[31:20])) | bus.in_imm[0];
      default: imm_bad = 1'b0;
    endcase
`else
    imm_bad = 1'b0;
`endif
  end

  // Occupancy: push+pop together holds; FULL never pushes since in_ready is low.
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY:   if (push) state_next = ONE;
        ONE:     if (push && !pop) state_next = FULL;
                 else if (pop && !push) state_next = EMPTY;
        FULL:    if (pop) state_next = ONE;
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= EMPTY;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem[0] <= 32'h0;
      mem[1] <= 32'h0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      addr_q <= BASE_ADDR;
      err    <= 1'b0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      addr_q <= BASE_ADDR;
      err    <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= instr;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
        addr_q <= addr_q + 32'(ADDR_STEP);
      end
      if (accept && (fmt_bad || imm_bad)) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// tb_rv32i_instr_encoder
// Purpose: scoreboard bench for rv32i_instr_encoder. Accepted requests push
//   their expected word/address into a queue; a monitor pops and compares on
//   every output handshake. Directed words use hand-assembled constants,
//   random words use an arithmetic reference model.
module tb_rv32i_instr_encoder;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          STEP = 4;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } req_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  logic err;

  rv32i_instr_encoder_if bus ();

  rv32i_instr_encoder #(.BASE_ADDR(BASE), .ADDR_STEP(STEP)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus.slave),
    .err   (err)
  );

  always #5 clk = ~clk;

  exp_t expQ[$];
  int   pushCount = 0;
  logic errExp = 1'b0;
  int   errors = 0;
  int   checks = 0;
  bit   randDone = 1'b0;

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: field placement expressed as shifts of the spec's bit ranges.
  function automatic logic [31:0] modelEncode(input req_t r);
    logic [31:0] imm = r.imm;
    logic [31:0] base = (32'(r.rd) << 7) | 32'(r.op);
    logic [31:0] regs = (32'(r.rs2) << 20) | (32'(r.rs1) << 15) | (32'(r.f3) << 12);
    logic [31:0] iField;
    case (r.fmt)
      3'd0: return (32'(r.f7) << 25) | regs | base;
      3'd1: begin
        if (r.op == 7'h13 && (r.f3 == 3'd1 || r.f3 == 3'd5))
          iField = (32'(r.f7) << 5) | (imm & 32'h1f);
        else
          iField = imm & 32'hfff;
        return (iField << 20) | (32'(r.rs1) << 15) | (32'(r.f3) << 12) | base;
      end
      3'd2: return (((imm >> 5) & 32'h7f) << 25) | regs | ((imm & 32'h1f) << 7) | 32'(r.op);
      3'd3: return (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3f) << 25) | regs |
                   (((imm >> 1) & 32'hf) << 8) | (((imm >> 11) & 1) << 7) | 32'(r.op);
      3'd4: return (imm & 32'hffff_f000) | base;
      default: return (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3ff) << 21) |
                      (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hff) << 12) | base;
    endcase
  endfunction

  function automatic bit modelDrop(input req_t r);
    int s;
    s = $signed(r.imm);
    if (r.fmt > 3'd5) return 1'b1;
`ifdef ENCODER_IMM_CHECK_EN
    case (r.fmt)
      3'd1: if (!(r.op == 7'h13 && (r.f3 == 3'd1 || r.f3 == 3'd5)))
              return (s < -2048) || (s > 2047);
      3'd2: return (s < -2048) || (s > 2047);
      3'd3: return (s < -4096) || (s > 4094) || r.imm[0];
      3'd4: return r.imm[11:0] != 12'h0;
      3'd5: return (s < -(1 << 20)) || (s > (1 << 20) - 2) || r.imm[0];
      default: return 1'b0;
    endcase
`endif
    return 1'b0;
  endfunction

  // Drives one request, waits (bounded) for acceptance, records the expectation.
  task automatic applyStimulus(input req_t r, input bit useConst, input logic [31:0] constInstr);
    exp_t e;
    int waitCycles = 0;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_format = r.fmt;
    bus.in_opcode = r.op;
    bus.in_funct3 = r.f3;
    bus.in_funct7 = r.f7;
    bus.in_rd     = r.rd;
    bus.in_rs1    = r.rs1;
    bus.in_rs2    = r.rs2;
    bus.in_imm    = r.imm;
    #1;
    while (!bus.in_ready && waitCycles < 200) begin
      @(negedge clk);
      #1;
      waitCycles++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: in_ready stayed 0 expected 1 at %0t", $time);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (modelDrop(r)) begin
      errExp = 1'b1;
    end else begin
      e.instr = useConst ? constInstr : modelEncode(r);
      e.addr  = BASE + 32'(STEP * pushCount);
      expQ.push_back(e);
      pushCount++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic checkOutput();
    exp_t e;
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected_word: got %h expected no word at %0t", bus.out_instr, $time);
      return;
    end
    e = expQ.pop_front();
    checkValue("out_instr", bus.out_instr, e.instr);
    checkValue("out_addr", bus.out_addr, e.addr);
  endtask

  // Monitor: every output handshake pops one expectation.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!reset && !flush && bus.out_valid && bus.out_ready) checkOutput();
    end
  end

  task automatic doFlush();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    expQ.delete();
    pushCount = 0;
    errExp = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((expQ.size() != 0 || bus.out_valid) && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkValue("drain_pending", 32'(expQ.size()), 32'd0);
  endtask

  function automatic req_t mk(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [31:0] imm);
    req_t r;
    r.fmt = fmt; r.op = op; r.f3 = f3; r.f7 = f7;
    r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.imm = imm;
    return r;
  endfunction

  initial begin
    req_t r;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_format = 3'd0; bus.in_opcode = 7'd0; bus.in_funct3 = 3'd0; bus.in_funct7 = 7'd0;
    bus.in_rd = 5'd0; bus.in_rs1 = 5'd0; bus.in_rs2 = 5'd0; bus.in_imm = 32'd0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkValue("reset_in_ready", 32'(bus.in_ready), 32'd1);
    checkValue("reset_out_valid", 32'(bus.out_valid), 32'd0);
    checkValue("reset_out_instr", bus.out_instr, 32'h0);
    checkValue("reset_out_addr", bus.out_addr, BASE);
    checkValue("reset_err", 32'(err), 32'd0);

    // Directed encodings with hand-assembled expectations.
    bus.out_ready = 1'b1;
    applyStimulus(mk(3'd0, 7'b0110011, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'h0), 1'b1, 32'h002081B3);
    #1;
    checkValue("latency_out_valid", 32'(bus.out_valid), 32'd1);
    applyStimulus(mk(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF), 1'b1, 32'hFFF00093);
    applyStimulus(mk(3'd3, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8), 1'b1, 32'h00208463);
    applyStimulus(mk(3'd5, 7'b1101111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048), 1'b1, 32'h001000EF);
    applyStimulus(mk(3'd4, 7'b0110111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h12345000), 1'b1, 32'h123450B7);
    // srai x5,x6,3: funct7 0100000 lands in imm[11:5]
    applyStimulus(mk(3'd1, 7'b0010011, 3'd5, 7'h20, 5'd5, 5'd6, 5'd0, 32'd3), 1'b1, 32'h40335293);
    drain();

    // Illegal format: dropped, err set; then flush clears.
    applyStimulus(mk(3'd7, 7'h33, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 32'h0), 1'b0, 32'h0);
    @(negedge clk);
    #1;
    checkValue("illegal_err", 32'(err), 32'(errExp));
    checkValue("illegal_no_word", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;
    doFlush();
    #1;
    checkValue("flush_err", 32'(err), 32'd0);
    checkValue("flush_out_valid", 32'(bus.out_valid), 32'd0);
    checkValue("flush_out_addr", bus.out_addr, BASE);

    // Backpressure: two accepts fill the FIFO, third waits until release.
    applyStimulus(mk(3'd0, 7'b0110011, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'h0), 1'b1, 32'h002081B3);
    applyStimulus(mk(3'd4, 7'b0110111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h12345000), 1'b1, 32'h123450B7);
    #1;
    checkValue("full_in_ready", 32'(bus.in_ready), 32'd0);
    checkValue("full_head_addr", bus.out_addr, BASE);
    fork
      applyStimulus(mk(3'd3, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8), 1'b1, 32'h00208463);
      begin
        repeat (3) @(negedge clk);
        bus.out_ready = 1'b1;
      end
    join
    drain();
    checkValue("addr_after_three", bus.out_addr, BASE + 32'(3 * STEP));

    // Flush colliding with an accept: the request is discarded.
    bus.out_ready = 1'b0;
    applyStimulus(mk(3'd0, 7'b0110011, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'h0), 1'b1, 32'h002081B3);
    @(negedge clk);
    flush = 1'b1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    expQ.delete();
    pushCount = 0;
    errExp = 1'b0;
    #1;
    checkValue("flush_accept_out_valid", 32'(bus.out_valid), 32'd0);
    checkValue("flush_accept_in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;

    // addi x1,x0,2048: out of range for a 12-bit immediate.
    applyStimulus(mk(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048), 1'b1, 32'h80000093);
    drain();
    checkValue("imm2048_err", 32'(err), 32'(errExp));

    // Randomized requests with random backpressure.
    fork
      begin
        for (int i = 0; i < 250; i++) begin
          int k;
          k = $urandom_range(0, 15);
          r.fmt = (k < 14) ? 3'(k % 6) : 3'(6 + k % 2);
          r.op  = 7'($urandom);
          r.f3  = 3'($urandom);
          r.f7  = 7'($urandom);
          r.rd  = 5'($urandom);
          r.rs1 = 5'($urandom);
          r.rs2 = 5'($urandom);
          if (r.fmt == 3'd1 && $urandom_range(0, 1) == 1) r.op = 7'b0010011;
          case ($urandom_range(0, 3))
            0: r.imm = 32'($urandom_range(0, 4095)) - 32'd2048;
            1: r.imm = $urandom;
            2: r.imm = (32'($urandom_range(0, 4095)) - 32'd2048) << 1;
            default: r.imm = {20'($urandom), 12'h0};
          endcase
          applyStimulus(r, 1'b0, 32'h0);
        end
        randDone = 1'b1;
      end
      begin
        while (!randDone) begin
          @(negedge clk);
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();
    checkValue("random_err", 32'(err), 32'(errExp));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
